// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, frame length and default timing.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5
    } ps2_state_e;

    localparam int FRAME_BITS      = 11;
    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int DEF_INHIBIT_CYC = 5000;
    localparam int DEF_TIMEOUT_CYC = 750_000;
    localparam int DEF_FILT_CYC    = 8;

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus stability filter for one PS/2 pad; reports the
// filtered level and a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILT_CYC = DEF_FILT_CYC
) (
    input  logic clk,
    input  logic clrn,
    input  logic pad,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;

    // Synchronize the pad, then accept a new level only after FILT_CYC stable samples
    always_ff @(posedge clk) begin
        if (!clrn) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            fall_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            sync1_r <= pad;
            sync2_r <= sync1_r;
            fall_r  <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                fall_r  <= level_r;
                cnt_r   <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request to
// send, shifts out data/parity/stop on device clock falls and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int FILT_CYC    = DEF_FILT_CYC
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wrn,
    input  logic [7:0] din,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYC - 1);
    localparam logic [IW-1:0] INH_ONE  = IW'(32'd1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_ONE   = TW'(32'd1);
    localparam logic [3:0]    PAR_EDGE = 4'd8;

    if (CLK_HZ < 1 || INHIBIT_CYC < 1 || TIMEOUT_CYC < 1 || FILT_CYC < 1) begin : g_bad_param
        $error("ps2_host_tx: timing parameters must be positive");
    end

    logic clk_lvl_s;
    logic clk_fall_s;
    logic data_lvl_s;
    logic data_fall_unused_s;

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_clk_filt (
        .clk   (clk),
        .clrn  (clrn),
        .pad   (ps2_clk_in),
        .level (clk_lvl_s),
        .fall  (clk_fall_s)
    );

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_data_filt (
        .clk   (clk),
        .clrn  (clrn),
        .pad   (ps2_data_in),
        .level (data_lvl_s),
        .fall  (data_fall_unused_s)
    );

    ps2_state_e    state_r, state_n;
    logic [7:0]    data_r, data_n;
    logic          parity_r, parity_n;
    logic [3:0]    bit_cnt_r, bit_cnt_n;
    logic [IW-1:0] inh_cnt_r, inh_cnt_n;
    logic [TW-1:0] to_cnt_r, to_cnt_n;
    logic          clk_oe_r, clk_oe_n;
    logic          data_oe_r, data_oe_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic          ack_err_r, ack_err_n;

    // State and datapath registers; every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r   <= ST_IDLE;
            data_r    <= 8'h00;
            parity_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            inh_cnt_r <= {IW{1'b0}};
            to_cnt_r  <= {TW{1'b0}};
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            state_r   <= state_n;
            data_r    <= data_n;
            parity_r  <= parity_n;
            bit_cnt_r <= bit_cnt_n;
            inh_cnt_r <= inh_cnt_n;
            to_cnt_r  <= to_cnt_n;
            clk_oe_r  <= clk_oe_n;
            data_oe_r <= data_oe_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            ack_err_r <= ack_err_n;
        end
    end

    // Next-state and next-output logic for the transmit sequence
    always_comb begin
        state_n   = state_r;
        data_n    = data_r;
        parity_n  = parity_r;
        bit_cnt_n = bit_cnt_r;
        inh_cnt_n = inh_cnt_r;
        to_cnt_n  = to_cnt_r;
        clk_oe_n  = clk_oe_r;
        data_oe_n = data_oe_r;
        busy_n    = busy_r;
        done_n    = 1'b0;
        ack_err_n = ack_err_r;
        case (state_r)
            ST_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                busy_n    = 1'b0;
                if (!wrn) begin
                    data_n    = din;
                    parity_n  = odd_parity(din);
                    ack_err_n = 1'b0;
                    busy_n    = 1'b1;
                    clk_oe_n  = 1'b1;
                    inh_cnt_n = {IW{1'b0}};
                    state_n   = ST_INHIBIT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                // Clock release and start bit leave INHIBIT on the same edge
                if (inh_cnt_r == INH_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    to_cnt_n  = {TW{1'b0}};
                    bit_cnt_n = 4'd0;
                    state_n   = ST_REQ;
                end else begin
                    inh_cnt_n = inh_cnt_r + INH_ONE;
                end
            end
            ST_REQ, ST_SHIFT, ST_ACK: begin
                if (to_cnt_r == TO_LAST) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    ack_err_n = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = ST_IDLE;
                end else begin
                    to_cnt_n = to_cnt_r + TO_ONE;
                    if (state_r == ST_REQ) begin
                        state_n = ST_SHIFT;
                    end else if (!clk_fall_s) begin
                        state_n = state_r;
                    end else if (state_r == ST_SHIFT) begin
                        // bit_cnt_r holds the number of falls already seen
                        bit_cnt_n = bit_cnt_r + 4'd1;
                        if (bit_cnt_r < PAR_EDGE) begin
                            data_oe_n = ~data_r[bit_cnt_r[2:0]];
                        end else if (bit_cnt_r == PAR_EDGE) begin
                            data_oe_n = ~parity_r;
                        end else begin
                            data_oe_n = 1'b0;
                            state_n   = ST_ACK;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt_r + 4'd1;
                        if (!data_lvl_s) begin
                            state_n = ST_WAIT_REL;
                        end else begin
                            ack_err_n = 1'b1;
                            busy_n    = 1'b0;
                            state_n   = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_REL: begin
                if (clk_lvl_s && data_lvl_s) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_WAIT_REL;
                end
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                busy_n    = 1'b0;
                state_n   = ST_IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign ack_err     = ack_err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 500;
    localparam int TO   = 4000;
    localparam int FILT = 8;
    localparam int HALF = 100;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_INJECT = 3;
    localparam int M_RESET  = 4;

    typedef struct {
        logic [7:0]  din;
        int          mode;
        int          ev;
        logic [10:0] exp_frame;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    logic       clk  = 1'b0;
    logic       clrn = 1'b0;
    logic       wrn  = 1'b1;
    logic [7:0] din  = 8'h00;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, ack_err;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .CLK_HZ      (50_000_000),
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO),
        .FILT_CYC    (FILT)
    ) dut (
        .clk         (clk),
        .clrn        (clrn),
        .wrn         (wrn),
        .din         (din),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected wire frame {stop, parity, data LSB-first, start}: odd parity by counting ones
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Issue one write and play the device side; cap collects what the device saw
    task automatic send(input logic [7:0] d, input int mode, input int ev,
                        output logic [10:0] cap, output int inh_len);
        cap      = 11'd0;
        inh_len  = 0;
        done_cnt = 0;
        din = d;
        wrn = 1'b0;
        tick(1);
        wrn = 1'b1;
        while (ps2_clk_oe === 1'b1 && inh_len < INH + 100) begin
            inh_len++;
            tick(1);
        end
        check("start_drive", {31'd0, ps2_data_oe}, 32'd1);
        if (mode == M_SILENT) return;
        tick(50);
        cap[0] = ps2_data_in;
        for (int n = 1; n <= 11; n++) begin
            dev_clk_low = 1'b1;
            for (int t = 0; t < HALF; t++) begin
                tick(1);
                if (mode == M_INJECT && n == ev) begin
                    if (t == 0) begin
                        din = 8'hAA;
                        wrn = 1'b0;
                    end else if (t == 1) begin
                        wrn = 1'b1;
                    end
                end
                if (mode == M_RESET && n == ev) begin
                    if (t == 0) begin
                        clrn = 1'b0;
                    end else if (t == 1) begin
                        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                        check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                        check("rst_busy", {31'd0, busy}, 32'd0);
                        clrn = 1'b1;
                        dev_clk_low  = 1'b0;
                        dev_data_low = 1'b0;
                        tick(30);
                        return;
                    end
                end
            end
            if (n <= 10) cap[n] = ps2_data_in;
            dev_clk_low = 1'b0;
            if (n == 10 && mode != M_NOACK) dev_data_low = 1'b1;
            if (n == 11) dev_data_low = 1'b0;
            tick(HALF);
        end
        tick(30);
    endtask

    initial begin
        vec_t        tbl[5];
        logic [10:0] cap;
        logic [7:0]  d;
        int          inh_len;
        int          cnt;
        int          mode;

        tbl[0] = '{8'hED, M_ACK,    0, {1'b1, 1'b1, 8'hED, 1'b0}, 1, 1'b0};
        tbl[1] = '{8'h01, M_ACK,    0, {1'b1, 1'b0, 8'h01, 1'b0}, 1, 1'b0};
        tbl[2] = '{8'h3C, M_NOACK,  0, {1'b1, 1'b1, 8'h3C, 1'b0}, 0, 1'b1};
        tbl[3] = '{8'h12, M_INJECT, 4, {1'b1, 1'b1, 8'h12, 1'b0}, 1, 1'b0};
        tbl[4] = '{8'h80, M_ACK,    0, {1'b1, 1'b0, 8'h80, 1'b0}, 1, 1'b0};

        clrn = 1'b0;
        tick(3);
        check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ack_err", {31'd0, ack_err}, 32'd0);
        clrn = 1'b1;
        tick(20);

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].din, tbl[i].mode, tbl[i].ev, cap, inh_len);
            check("inhibit_len", inh_len, INH);
            check("frame", {21'd0, cap}, {21'd0, tbl[i].exp_frame});
            check("done_pulses", done_cnt, tbl[i].exp_done);
            check("ack_err", {31'd0, ack_err}, {31'd0, tbl[i].exp_err});
            check("busy_end", {31'd0, busy}, 32'd0);
            if (tbl[i].mode == M_INJECT) begin
                cnt = 0;
                for (int t = 0; t < 700; t++) begin
                    tick(1);
                    if (ps2_clk_oe === 1'b1) cnt++;
                end
                check("no_second_frame", cnt, 0);
                check("no_second_done", done_cnt, 1);
            end
        end

        // Device never clocks: timeout counted from the clock release
        send(8'h55, M_SILENT, 0, cap, inh_len);
        cnt = 0;
        while (ack_err !== 1'b1 && cnt < TO + 200) begin
            tick(1);
            cnt++;
        end
        check("timeout_cycles", cnt, TO);
        check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("timeout_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_done", done_cnt, 0);
        tick(20);

        // Reset in the middle of a frame, then a normal write
        send(8'h99, M_RESET, 4, cap, inh_len);
        check("post_rst_ack_err", {31'd0, ack_err}, 32'd0);
        send(8'hF4, M_ACK, 0, cap, inh_len);
        check("f4_frame", {21'd0, cap}, {21'd0, model_frame(8'hF4)});
        check("f4_done", done_cnt, 1);
        check("f4_ack_err", {31'd0, ack_err}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom);
            mode = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
            send(d, mode, 0, cap, inh_len);
            check("rnd_inhibit_len", inh_len, INH);
            check("rnd_frame", {21'd0, cap}, {21'd0, model_frame(d)});
            check("rnd_done", done_cnt, (mode == M_ACK) ? 1 : 0);
            check("rnd_ack_err", {31'd0, ack_err}, (mode == M_NOACK) ? 32'd1 : 32'd0);
            check("rnd_busy", {31'd0, busy}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 Parameter INHIBIT_CYC, default 5000, clk cycles the PS/2 clock is held low before the request (100 us at 50 MHz).
REQ-003 Parameter TIMEOUT_CYC, default 750_000, clk cycles allowed from clock release to ACK (15 ms).
REQ-004 Parameter FILT_CYC, default 8, clk cycles a filtered PS/2 input must be stable to change level.
REQ-005 Port clk  in  1  system clock; all logic is single-clock, rising edge.
REQ-006 Port clrn  in  1  reset; synchronous, active-low.
REQ-007 Port wrn  in  1  write strobe, active-low, sampled each clk.
REQ-008 Port din  in  8  command byte to send to the device.
REQ-009 Port ps2_clk_in  in  1  PS/2 clock pad level, asynchronous.
REQ-010 Port ps2_data_in  in  1  PS/2 data pad level, asynchronous.
REQ-011 Port ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (open-drain).
REQ-012 Port ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-013 Port busy  out  1  transfer in progress; the receiver ignores the bus while busy=1.
REQ-014 Port done  out  1  one-cycle pulse on successful ACK.
REQ-015 Port ack_err  out  1  level; set on missing ACK or timeout, cleared by the next accepted write.

Function
REQ-016 Both PS/2 inputs pass a 2-flop synchronizer, then a stability filter of FILT_CYC cycles; a falling edge is a filtered 1->0 transition.
REQ-017 States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_REL.
REQ-018 IDLE: wrn=0 latches din, computes odd parity (bit = ~^din), clears ack_err, sets busy=1, enters INHIBIT the next cycle.
REQ-019 wrn=0 while busy=1 is ignored; the frame in flight and din latch are unchanged.
REQ-020 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then ps2_data_oe=1 (start bit) and the block enters REQ.
REQ-021 REQ: ps2_clk_oe=0 on the first REQ cycle, ps2_data_oe held 1, the timeout counter starts, and the block enters SHIFT.
REQ-022 SHIFT: falling edges 1-8 each set ps2_data_oe = ~din[n-1] (LSB first); edge 9 sets ps2_data_oe = ~parity; edge 10 sets ps2_data_oe=0 (stop); then the block enters ACK.
REQ-023 ACK: on falling edge 11, sampled ps2_data=0 -> enter WAIT_REL; sampled 1 -> set ack_err, busy=0, enter IDLE.
REQ-024 WAIT_REL: once both filtered lines are high, done pulses for 1 cycle, busy=0, and the block enters IDLE.
REQ-025 A timeout counter reaching TIMEOUT_CYC in REQ, SHIFT or ACK releases both lines, sets ack_err, sets busy=0, and returns to IDLE in the same cycle.
REQ-026 The bit counter is 4 bits, counts 0..11 and never wraps; falling edges outside SHIFT/ACK are ignored.
REQ-027 Only ps2_clk_oe=1 and ps2_data_oe=1 are allowed simultaneously in INHIBIT; the block never drives a line high.

Reset
REQ-028 clrn=0 at a clk edge forces IDLE, ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0, and clears all counters and filters (filtered levels = 1), including mid-frame.

Structure
REQ-029 The shared package ps2_pkg holds the state encoding, FRAME_BITS=11 and the default timing constants; the package is also used by ps2_kbd.
REQ-030 The sync+filter is one sub-module, ps2_line_filter, instantiated twice; it is reusable by ps2_kbd.

Verification
REQ-031 din=8'hED, device model clocks at a 200-clk period and ACKs -> clock low for 5000 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop 1; done pulses once; ack_err=0.
REQ-032 din=8'h01 -> parity bit 0 is observed on data at edge 9; done=1.
REQ-033 Device ACK withheld (data high at edge 11) -> ack_err=1, busy=0, done never pulses.
REQ-034 No device clocks after release -> ack_err=1 exactly 750_000 cycles after ps2_clk_oe falls; both oe=0.
REQ-035 wrn=0 with din=8'hAA during the data bit 3 frame -> transmitted byte is still the original; no second frame follows.
REQ-036 clrn=0 at edge 4 -> next clk has both oe=0, busy=0; a following write of 8'hF4 completes normally.
